// File: rtl/mmio_console_tx.sv
// MMIO console / termination peripheral.
// Snoops CPU stores to the MMIO window (addr[31] set), queues printable
// characters in a small FIFO and shifts them out as 8N1 UART frames.
// A store of FINI_CODE raises a sticky finish flag; done_o follows once
// every queued character has fully left the serial line.
module mmio_console_tx #(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [31:0] FINI_CODE    = 32'h00020000
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [31:0]                   dbus_addr_i,
   input  logic                          dbus_wvalid_i,
   input  logic [31:0]                   dbus_wdata_i,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
   output logic                          ovf_o,
   output logic                          fini_o,
   output logic                          done_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [AW:0]   C_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          r_state, w_next;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [AW:0]     r_cnt;
   logic            r_ovf, r_fini;
   logic [CW-1:0]   r_clk;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic            r_tx;
   logic            r_line_busy;

   logic w_hit, w_is_fini, w_push_req, w_full, w_empty, w_push, w_pop, w_bit_end;
   logic w_unused_addr;

   assign w_hit      = dbus_wvalid_i && dbus_addr_i[31];
   assign w_is_fini  = (dbus_wdata_i == FINI_CODE);
   assign w_push_req = w_hit && !w_is_fini && !r_fini;
   assign w_full     = (r_cnt == C_FULL);
   assign w_empty    = (r_cnt == '0);
   // Fullness is judged before any same-cycle pop, so a push on full is lost.
   assign w_push     = w_push_req && !w_full;
   assign w_bit_end  = (r_clk == C_LAST);
   assign w_unused_addr = ^dbus_addr_i[30:0];

   // State register for the transmitter FSM.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic and FIFO pop request.
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = S_START;
            end
         end
         S_START: if (w_bit_end) w_next = S_DATA;
         S_DATA:  if (w_bit_end && (r_idx == 3'd7)) w_next = S_STOP;
         S_STOP:  if (w_bit_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Character storage; contents need no reset since pointers gate them.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= dbus_wdata_i[7:0];
   end

   // FIFO pointers, occupancy and sticky status flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_fini <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (w_push_req && w_full) r_ovf  <= 1'b1;
         if (w_hit && w_is_fini)   r_fini <= 1'b1;
      end
   end

   // Bit-period counter, data-bit index and shift register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_clk   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         if (r_state == S_IDLE || w_bit_end) r_clk <= '0;
         else                                r_clk <= r_clk + CW'(1);
         if (w_pop) begin
            r_shift <= r_mem[r_rptr];
         end else if (r_state == S_DATA && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
         end
      end
   end

   // Serial line register, one cycle behind the FSM; r_line_busy tracks the
   // same delay so busy/done cover the stop bit until it has left the pin.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tx        <= 1'b1;
         r_line_busy <= 1'b0;
      end else begin
         r_line_busy <= (r_state != S_IDLE);
         case (r_state)
            S_START: r_tx <= 1'b0;
            S_DATA:  r_tx <= r_shift[0];
            default: r_tx <= 1'b1;
         endcase
      end
   end

   assign tx_o       = r_tx;
   assign fifo_cnt_o = r_cnt;
   assign ovf_o      = r_ovf;
   assign fini_o     = r_fini;
   assign busy_o     = !w_empty || (r_state != S_IDLE) || r_line_busy;
   assign done_o     = r_fini && w_empty && (r_state == S_IDLE) && !r_line_busy;

endmodule

// File: tb/tb_mmio_console_tx.sv
// Testbench for mmio_console_tx (FIFO_DEPTH=4, CLKS_PER_BIT=4).
// A UART receiver model decodes the serial line into rx_q; expected
// characters come from the store rules applied to the issued stimulus.
module tb_mmio_console_tx;

   localparam int          D    = 4;
   localparam int          C    = 4;
   localparam logic [31:0] FINI = 32'h00020000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        wvalid = 1'b0;
   logic        tx, busy, ovf, fini, done;
   logic [2:0]  cnt;

   int total = 0;
   int bad   = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   bit         m_busy = 1'b0;
   int         m_cnt  = 0;
   logic [7:0] m_byte = '0;

   mmio_console_tx #(
      .FIFO_DEPTH   (D),
      .CLKS_PER_BIT (C),
      .FINI_CODE    (FINI)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .dbus_addr_i   (addr),
      .dbus_wvalid_i (wvalid),
      .dbus_wdata_i  (wdata),
      .tx_o          (tx),
      .busy_o        (busy),
      .fifo_cnt_o    (cnt),
      .ovf_o         (ovf),
      .fini_o        (fini),
      .done_o        (done)
   );

   always #5 clk = ~clk;

   // UART receiver: detect start, sample each bit near its centre.
   always @(negedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
      end else if (!m_busy) begin
         if (tx === 1'b0) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_byte = '0;
         end
      end else begin
         m_cnt++;
         for (int k = 0; k < 8; k++)
            if (m_cnt == C*(k+1) + C/2 - 1) m_byte[k] = tx;
         if (m_cnt == 9*C + C/2 - 1) begin
            total++;
            if (tx !== 1'b1) begin
               bad++;
               $display("FAIL stop_bit: tx=%b required 1", tx);
            end
            rx_q.push_back(m_byte);
            m_busy = 1'b0;
         end
      end
   end

   function automatic int first_diff();
      int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
      if (rx_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; wvalid = 1'b1;
   endtask

   task automatic release_bus();
      @(negedge clk);
      addr = '0; wdata = '0; wvalid = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      while ((busy !== 1'b0 || m_busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      total++;
      if ({tx, busy, cnt, ovf, fini, done} !== 8'b1_0_000_0_0_0) begin
         bad++;
         $display("FAIL reset_vals: got %b required 10000000", {tx, busy, cnt, ovf, fini, done});
      end
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single_char();
      logic [7:0] d = 8'h41;
      int n;
      logic exp_bit;
      rx_q.delete(); exp_q.delete(); exp_q.push_back(d);
      drive(32'h8000_0000, {24'h0, d});
      release_bus();                       // now half a cycle after edge N
      total++;
      if (tx !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_n0: tx=%b busy=%b required tx=1 busy=1", tx, busy);
      end
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || cnt !== 3'd0) begin
         bad++;
         $display("FAIL single_n1: tx=%b cnt=%0d required tx=1 cnt=0", tx, cnt);
      end
      for (int j = 0; j < 10*C; j++) begin
         @(negedge clk);
         if (j / C == 0)      exp_bit = 1'b0;
         else if (j / C == 9) exp_bit = 1'b1;
         else                 exp_bit = d[j/C - 1];
         total++;
         if (tx !== exp_bit) begin
            bad++;
            $display("FAIL single_wire[%0d]: tx=%b required %b", j, tx, exp_bit);
         end
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL single_busy_hold: busy=%b required 1", busy);
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         bad++;
         $display("FAIL single_busy_drop: busy=%b tx=%b required busy=0 tx=1", busy, tx);
      end
      wait_idle(200, n);
      total++;
      if (first_diff() != -1) begin
         bad++;
         $display("FAIL single_rx: got %0d chars, required %0d", rx_q.size(), exp_q.size());
      end
   endtask

   task automatic test_non_mmio();
      int lows = 0;
      rx_q.delete();
      drive(32'h0000_1000, 32'h41);
      release_bus();
      total++;
      if (cnt !== 3'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL nonmmio_cnt: cnt=%0d busy=%b required cnt=0 busy=0", cnt, busy);
      end
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      total++;
      if (lows != 0 || rx_q.size() != 0) begin
         bad++;
         $display("FAIL nonmmio_line: low samples=%0d chars=%0d required 0 and 0", lows, rx_q.size());
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int          n = $urandom_range(1, 8);
         int          hits = 0;
         int          first_hit = -1;
         int          exp_cnt;
         int          w;
         logic [31:0] a, d;
         rx_q.delete(); exp_q.delete();
         for (int i = 0; i < n; i++) begin
            a = $urandom; d = $urandom;
            if (hits == D) a[31] = 1'b0;
            if (a[31]) begin
               if (d == FINI) d = d ^ 32'h1;
               if (first_hit < 0) first_hit = i;
               hits++;
               exp_q.push_back(d[7:0]);
            end else if ($urandom_range(0, 3) == 0) begin
               d = FINI;
            end
            drive(a, d);
         end
         release_bus();
         // The transmitter takes the first hit one cycle after it lands.
         if (hits == 0)                exp_cnt = 0;
         else if (first_hit == n - 1)  exp_cnt = hits;
         else                          exp_cnt = hits - 1;
         total++;
         if (cnt !== 3'(exp_cnt)) begin
            bad++;
            $display("FAIL rand_cnt[%0d]: cnt=%0d required %0d", r, cnt, exp_cnt);
         end
         wait_idle(1000, w);
         total++;
         if (w >= 1000) begin
            bad++;
            $display("FAIL rand_timeout[%0d]: waited %0d cycles, required < 1000", r, w);
         end
         total++;
         if (first_diff() != -1 || ovf !== 1'b0 || fini !== 1'b0) begin
            bad++;
            $display("FAIL rand_rx[%0d]: chars=%0d ovf=%b fini=%b required chars=%0d ovf=0 fini=0",
                     r, rx_q.size(), ovf, fini, exp_q.size());
         end
      end
   endtask

   task automatic test_overflow();
      int w;
      int accepted;
      rx_q.delete(); exp_q.delete();
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("FAIL ovf_pre: ovf=%b required 0", ovf);
      end
      // Only the first character is popped during a burst shorter than a frame.
      accepted = (6 < D + 1) ? 6 : D + 1;
      for (int i = 0; i < 6; i++) begin
         if (i < accepted) exp_q.push_back(8'h61 + 8'(i));
         drive(32'h8000_0010, 32'h61 + 32'(i));
      end
      release_bus();
      total++;
      if (ovf !== 1'b1 || cnt !== 3'(accepted - 1)) begin
         bad++;
         $display("FAIL ovf_set: ovf=%b cnt=%0d required ovf=1 cnt=%0d", ovf, cnt, accepted - 1);
      end
      wait_idle(1000, w);
      total++;
      if (first_diff() != -1) begin
         bad++;
         $display("FAIL ovf_rx: got %0d chars (diff at %0d), required %0d",
                  rx_q.size(), first_diff(), exp_q.size());
      end
   endtask

   task automatic test_finish();
      int idx;
      int exp_idx;
      apply_reset();
      rx_q.delete(); exp_q.delete();
      exp_q.push_back(8'h48); exp_q.push_back(8'h69);
      drive(32'h8000_0000, 32'h48);
      drive(32'h8000_0000, 32'h69);
      total++;
      if (fini !== 1'b0) begin
         bad++;
         $display("FAIL fini_early: fini=%b required 0", fini);
      end
      drive(32'h8000_0000, FINI);
      drive(32'h8000_0000, 32'h58);
      total++;
      if (fini !== 1'b1) begin
         bad++;
         $display("FAIL fini_set: fini=%b required 1", fini);
      end
      release_bus();
      total++;
      if (cnt !== 3'd1 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL fini_discard: cnt=%0d ovf=%b required cnt=1 ovf=0", cnt, ovf);
      end
      // First start bit after edge N+2; each later frame follows 10*C+1 later.
      exp_idx = 2 + (exp_q.size() - 1) * (10*C + 1) + 10*C;
      idx = 3;
      while (done !== 1'b1 && idx < 400) begin
         @(negedge clk);
         idx++;
      end
      total++;
      if (idx != exp_idx) begin
         bad++;
         $display("FAIL done_time: done first seen at cycle %0d, required %0d", idx, exp_idx);
      end
      for (int j = 0; j < 60; j++) @(negedge clk);
      total++;
      if (first_diff() != -1 || done !== 1'b1 || cnt !== 3'd0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL fini_final: chars=%0d done=%b cnt=%0d ovf=%b required chars=2 done=1 cnt=0 ovf=0",
                  rx_q.size(), done, cnt, ovf);
      end
   endtask

   task automatic test_reset_midframe();
      int lows = 0;
      apply_reset();
      rx_q.delete();
      drive(32'h8000_0000, 32'h00);
      drive(32'h8000_0000, 32'h00);
      drive(32'h8000_0000, FINI);
      release_bus();
      for (int j = 0; j < 11; j++) @(negedge clk);
      total++;
      if (tx !== 1'b0 || fini !== 1'b1 || cnt !== 3'd1) begin
         bad++;
         $display("FAIL mid_pre: tx=%b fini=%b cnt=%0d required tx=0 fini=1 cnt=1", tx, fini, cnt);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({tx, busy, cnt, ovf, fini, done} !== 8'b1_0_000_0_0_0) begin
         bad++;
         $display("FAIL mid_reset: got %b required 10000000", {tx, busy, cnt, ovf, fini, done});
      end
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      rx_q.delete();
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      total++;
      if (lows != 0 || rx_q.size() != 0 || cnt !== 3'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_after: lows=%0d chars=%0d cnt=%0d busy=%b required 0 0 0 0",
                  lows, rx_q.size(), cnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_char();
      test_non_mmio();
      test_random();
      test_overflow();
      test_finish();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
